// File: rtl/mandel_pkg.sv
// -----------------------------------------------------------------------------
// mandel_pkg
//   Types and default dimensions shared by the coordinate distributor, the
//   iteration engines and the pixel collector.
//   Contents:
//     DEF_*              default screen size, engine count and iteration limits
//     rgb_t              24-bit packed pixel {r,g,b}
//     collector_state_e  pixel collector FSM states
//     grey_rgb()         replicate one 8-bit level onto all three channels
// -----------------------------------------------------------------------------
package mandel_pkg;

  localparam int DEF_PIXEL_DATA_WIDTH = 10;
  localparam int DEF_SCREEN_WIDTH     = 640;
  localparam int DEF_SCREEN_HEIGHT    = 480;
  localparam int DEF_NUM_ENGINES      = 30;
  localparam int DEF_ITER_WIDTH       = 8;
  localparam int DEF_MAX_ITER         = 255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STREAM  = 1'b1
  } collector_state_e;

  function automatic rgb_t grey_rgb(input logic [7:0] level);
    rgb_t pix;
    pix.r = level;
    pix.g = level;
    pix.b = level;
    return pix;
  endfunction

endpackage

// File: rtl/pixel_collector_iter_palette.sv
// -----------------------------------------------------------------------------
// iter_palette
//   Maps an engine iteration count to an RGB colour. Points that reached
//   MAX_ITER are inside the set and are drawn black; every other count picks
//   one of 16 fixed colours using its low four bits, so the bands repeat.
//   Ports:
//     iter_i  in   ITER_WIDTH  iteration count
//     rgb_o   out  rgb_t       colour for that count (combinational)
// -----------------------------------------------------------------------------
module iter_palette
  import mandel_pkg::*;
#(
  parameter int ITER_WIDTH = DEF_ITER_WIDTH,
  parameter int MAX_ITER   = DEF_MAX_ITER
) (
  input  logic [ITER_WIDTH-1:0] iter_i,
  output rgb_t                  rgb_o
);

  localparam logic [ITER_WIDTH-1:0] INSIDE_ITER = ITER_WIDTH'(MAX_ITER);

  // Blue through cyan, green and yellow to red, ending on white.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000080, 24'h0000FF, 24'h0040FF, 24'h0080FF,
    24'h00C0FF, 24'h00FFC0, 24'h00FF80, 24'h00FF40,
    24'h40FF00, 24'h80FF00, 24'hC0FF00, 24'hFFC000,
    24'hFF8000, 24'hFF4000, 24'hFF0000, 24'hFFFFFF
  };

  // Inside-set check takes priority over the banded table.
  always_comb begin
    rgb_o = '0;
    if (iter_i != INSIDE_ITER) begin
      rgb_o = rgb_t'(PALETTE[iter_i[3:0]]);
    end
  end

endmodule

// File: rtl/pixel_collector.sv
// -----------------------------------------------------------------------------
// pixel_collector
//   Waits for every iteration engine to report a finished pixel, latches the
//   whole batch, pulses fin_flag so the distributor advances and the engines
//   restart, then streams the batch out in raster order as valid/ready RGB
//   with start-of-frame and end-of-line markers.
//
//   Build option: define PIXEL_COLLECTOR_COLOUR_MAP_EN to colour pixels through
//   iter_palette (registered, prefetched one beat ahead). Without it the
//   top 8 bits of the iteration count are output as greyscale.
//
//   Ports:
//     clk        in   1                         system clock
//     reset      in   1                         synchronous, active-high
//     eng_done   in   NUM_ENGINES               per-engine result valid level
//     eng_iter   in   [ITER_WIDTH] x NUM_ENGINES iteration count per engine
//     fin_flag   out  1                         one-cycle "batch captured" pulse
//     out_data   out  24                        pixel {R,G,B}
//     out_valid  out  1                         stream valid
//     out_ready  in   1                         stream ready from sink
//     out_sof    out  1                         first pixel of the frame
//     out_eol    out  1                         last pixel of a line
// -----------------------------------------------------------------------------
module pixel_collector
  import mandel_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = DEF_PIXEL_DATA_WIDTH,
  parameter int SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
  parameter int NUM_ENGINES      = DEF_NUM_ENGINES,
  parameter int ITER_WIDTH       = DEF_ITER_WIDTH,
  parameter int MAX_ITER         = DEF_MAX_ITER
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ENGINES-1:0] eng_done,
  input  logic [ITER_WIDTH-1:0] eng_iter [NUM_ENGINES],
  output logic                  fin_flag,
  output logic [23:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  // The greyscale path takes the top byte of the count, and MAX_ITER must be
  // representable, so reject configurations that cannot work.
  if (ITER_WIDTH < 8) begin : g_bad_iter_width
    $error("pixel_collector: ITER_WIDTH must be at least 8");
  end
  if (MAX_ITER >= (1 << ITER_WIDTH)) begin : g_bad_max_iter
    $error("pixel_collector: MAX_ITER does not fit in ITER_WIDTH");
  end

  collector_state_e              state_q, state_d;
  logic [IDX_W-1:0]              beatIdx_q, beatIdx_d;
  logic [PIXEL_DATA_WIDTH-1:0]   x_q, x_d;
  logic [PIXEL_DATA_WIDTH-1:0]   y_q, y_d;
  logic                          fin_q;
  logic [ITER_WIDTH-1:0]         batchBuf_q [NUM_ENGINES];

  logic allDone;
  logic lastBeat;
  logic accept;
  logic capture;

  // A capture happens either from idle, or back-to-back when the final beat
  // of the current batch leaves in the same cycle the engines are all done;
  // the latter keeps the stream free of a bubble between batches.
  always_comb begin
    allDone  = &eng_done;
    lastBeat = (beatIdx_q == LAST_IDX);
    accept   = (state_q == STREAM) && out_ready;
    capture  = allDone && ((state_q == COLLECT) || (accept && lastBeat));
  end

  // Next-state logic for the FSM, beat index and raster position.
  always_comb begin
    state_d   = state_q;
    beatIdx_d = beatIdx_q;
    x_d       = x_q;
    y_d       = y_q;

    case (state_q)
      COLLECT: begin
        if (capture) begin
          state_d   = STREAM;
          beatIdx_d = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (lastBeat) begin
            beatIdx_d = '0;
            state_d   = capture ? STREAM : COLLECT;
          end else begin
            beatIdx_d = beatIdx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = COLLECT;
        beatIdx_d = '0;
      end
    endcase

    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Control registers; reset can land mid-stream and abandons the batch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      beatIdx_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beatIdx_q <= beatIdx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fin_q     <= capture;
    end
  end

  // Capture buffer holds no meaningful value until the first capture, so it
  // is left out of reset.
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      for (int e = 0; e < NUM_ENGINES; e++) begin
        batchBuf_q[e] <= eng_iter[e];
      end
    end
  end

`ifdef PIXEL_COLLECTOR_COLOUR_MAP_EN
  // The palette output is registered, so the colour for the beat about to be
  // shown is looked up one cycle early: from the engine inputs at capture,
  // otherwise from the buffer slot after the one being accepted.
  logic [IDX_W-1:0]      nextIdx;
  logic [ITER_WIDTH-1:0] palIter;
  rgb_t                  palRgb;
  rgb_t                  pixData_q;

  always_comb begin
    nextIdx = lastBeat ? '0 : beatIdx_q + 1'b1;
    palIter = capture ? eng_iter[0] : batchBuf_q[nextIdx];
  end

  iter_palette #(
    .ITER_WIDTH (ITER_WIDTH),
    .MAX_ITER   (MAX_ITER)
  ) u_iter_palette (
    .iter_i (palIter),
    .rgb_o  (palRgb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pixData_q <= '0;
    end else if (capture || accept) begin
      pixData_q <= palRgb;
    end
  end

  assign out_data = out_valid ? pixData_q : '0;
`else
  assign out_data = out_valid ? grey_rgb(batchBuf_q[beatIdx_q][ITER_WIDTH-1 -: 8]) : '0;
`endif

  assign fin_flag  = fin_q;
  assign out_valid = (state_q == STREAM);
  assign out_sof   = out_valid && (x_q == '0) && (y_q == '0);
  assign out_eol   = out_valid && (x_q == X_LAST);

endmodule

// File: tb/tb_pixel_collector.sv
// -----------------------------------------------------------------------------
// tb_pixel_collector
//   Drives pixel_collector with four engines on a 6x2 screen. Expected stream
//   contents come from a queue of captured iteration counts and a running
//   count of accepted pixels; raster position is derived from that count with
//   division and modulo.
// -----------------------------------------------------------------------------
module tb_pixel_collector;

  localparam int NE = 4;
  localparam int SW = 6;
  localparam int SH = 2;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] eng_done;
  logic [IW-1:0] eng_iter [NE];
  logic          fin_flag;
  logic [23:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  logic [IW-1:0] pendQ [$];
  int            pixCount;
  logic          expFin;

  pixel_collector #(
    .PIXEL_DATA_WIDTH (10),
    .SCREEN_WIDTH     (SW),
    .SCREEN_HEIGHT    (SH),
    .NUM_ENGINES      (NE),
    .ITER_WIDTH       (IW),
    .MAX_ITER         (255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .eng_done  (eng_done),
    .eng_iter  (eng_iter),
    .fin_flag  (fin_flag),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

`ifdef PIXEL_COLLECTOR_COLOUR_MAP_EN
  function automatic logic [23:0] pixOf(input logic [IW-1:0] it);
    logic [23:0] tbl [16];
    tbl = '{24'h000080, 24'h0000FF, 24'h0040FF, 24'h0080FF,
            24'h00C0FF, 24'h00FFC0, 24'h00FF80, 24'h00FF40,
            24'h40FF00, 24'h80FF00, 24'hC0FF00, 24'hFFC000,
            24'hFF8000, 24'hFF4000, 24'hFF0000, 24'hFFFFFF};
    if (it == 8'd255) return 24'h000000;
    return tbl[it % 16];
  endfunction
`else
  function automatic logic [23:0] pixOf(input logic [IW-1:0] it);
    return {it, it, it};
  endfunction
`endif

  task automatic checkEq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic checkOutput(input string tag);
    logic expValid;
    logic [23:0] expData;
    int x, y;
    expValid = (pendQ.size() > 0);
    expData  = expValid ? pixOf(pendQ[0]) : 24'h0;
    x = pixCount % SW;
    y = (pixCount / SW) % SH;
    checkEq({tag, " valid"}, 24'(out_valid), 24'(expValid));
    checkEq({tag, " data"},  out_data, expData);
    checkEq({tag, " sof"},   24'(out_sof), 24'(expValid && x == 0 && y == 0));
    checkEq({tag, " eol"},   24'(out_eol), 24'(expValid && x == SW - 1));
    checkEq({tag, " fin"},   24'(fin_flag), 24'(expFin));
  endtask

  // One clock with the given engine-done and sink-ready levels; the model
  // applies the same edge, then outputs are checked 1 time unit later.
  task automatic applyStimulus(input logic [NE-1:0] done, input logic rdy, input string tag);
    logic acc, cap;
    eng_done  = done;
    out_ready = rdy;
    @(posedge clk);
    acc = (pendQ.size() > 0) && rdy;
    cap = (&done) && (pendQ.size() == 0 || (pendQ.size() == 1 && acc));
    if (acc) begin
      void'(pendQ.pop_front());
      pixCount++;
    end
    if (cap) begin
      for (int e = 0; e < NE; e++) pendQ.push_back(eng_iter[e]);
    end
    expFin = cap;
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset(input string tag);
    reset    = 1'b1;
    eng_done = '0;
    @(posedge clk);
    pendQ.delete();
    pixCount = 0;
    expFin   = 1'b0;
    #1;
    reset = 1'b0;
    checkOutput(tag);
  endtask

  task automatic setIter(input logic [IW-1:0] a, b, c, d);
    eng_iter[0] = a;
    eng_iter[1] = b;
    eng_iter[2] = c;
    eng_iter[3] = d;
  endtask

  task automatic randIter();
    for (int e = 0; e < NE; e++) eng_iter[e] = IW'($urandom);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    eng_done  = '0;
    setIter(0, 0, 0, 0);
    pixCount  = 0;
    expFin    = 1'b0;

    applyReset("reset");

    // 1: single batch, greyscale ramp
    setIter(10, 20, 30, 40);
    applyStimulus(4'b1111, 1'b1, "t1 cap");
    checkEq("t1 fin pulse", 24'(fin_flag), 24'h1);
    checkEq("t1 sof beat0", 24'(out_sof), 24'h1);
`ifndef PIXEL_COLLECTOR_COLOUR_MAP_EN
    checkEq("t1 beat0 grey", out_data, 24'h0A0A0A);
`endif
    for (int b = 0; b < 4; b++) applyStimulus(4'b0000, 1'b1, "t1 beat");
    checkEq("t1 idle valid", 24'(out_valid), 24'h0);

    // 2: batches across line and frame wrap
    for (int n = 0; n < 3; n++) begin
      randIter();
      applyStimulus(4'b1111, 1'b1, "t2 cap");
      for (int b = 0; b < 4; b++) applyStimulus(4'b0000, 1'b1, "t2 beat");
    end
    checkEq("t2 pixel count", 24'(pixCount), 24'd16);

    // 3: sink back-pressure on beat 2
    randIter();
    applyStimulus(4'b1111, 1'b1, "t3 cap");
    applyStimulus(4'b0000, 1'b1, "t3 beat1");
    applyStimulus(4'b0000, 1'b1, "t3 beat2");
    for (int s = 0; s < 3; s++) applyStimulus(4'b0000, 1'b0, "t3 stall");
    applyStimulus(4'b0000, 1'b1, "t3 beat3");
    applyStimulus(4'b0000, 1'b1, "t3 drain");

    // 4: partial done never captures
    randIter();
    for (int s = 0; s < 10; s++) applyStimulus(4'b1011, 1'b1, "t4 partial");
    checkEq("t4 no valid", 24'(out_valid), 24'h0);
    applyStimulus(4'b1111, 1'b1, "t4 cap");
    for (int b = 0; b < 4; b++) applyStimulus(4'b0000, 1'b1, "t4 beat");

    // 5: back-to-back batches with done held high
    for (int s = 0; s < 12; s++) begin
      randIter();
      applyStimulus(4'b1111, 1'b1, "t5 b2b");
    end
    for (int s = 0; s < 4; s++) applyStimulus(4'b0000, 1'b1, "t5 drain");

    // 6: reset mid-stream at beat 2
    randIter();
    applyStimulus(4'b1111, 1'b1, "t6 cap");
    applyStimulus(4'b0000, 1'b1, "t6 beat1");
    applyStimulus(4'b0000, 1'b1, "t6 beat2");
    applyReset("t6 reset");
    randIter();
    applyStimulus(4'b1111, 1'b1, "t6 recap");
    checkEq("t6 sof after reset", 24'(out_sof), 24'h1);
    for (int b = 0; b < 4; b++) applyStimulus(4'b0000, 1'b1, "t6 beat");

`ifdef PIXEL_COLLECTOR_COLOUR_MAP_EN
    setIter(255, 3, 0, 15);
    applyStimulus(4'b1111, 1'b1, "pal cap");
    checkEq("pal inside", out_data, 24'h000000);
    applyStimulus(4'b0000, 1'b1, "pal beat1");
    checkEq("pal entry3", out_data, 24'h0080FF);
    for (int b = 0; b < 3; b++) applyStimulus(4'b0000, 1'b1, "pal beat");
`endif

    // Randomized traffic
    for (int s = 0; s < 400; s++) begin
      logic [NE-1:0] d;
      randIter();
      d = ($urandom_range(0, 2) == 0) ? 4'b1111 : NE'($urandom);
      applyStimulus(d, 1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
